// File: rtl/mem_loader.sv
// mem_loader: boot loader that assembles a little-endian byte stream into words,
// writes them to the core's memory and holds the core in reset until the image is in.
module mem_loader #(
    parameter int                ADDR_W = 13,
    parameter int                DATA_W = 18,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    output logic              core_hold,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {HDR_LO, HDR_HI, B0, B1, B2, WR, DONE, ERR} state_t;
    state_t            state_q, state_d;
    logic [7:0]        lo_q, lo_d, b0_q, b0_d, b1_q, b1_d;
    logic [12:0]       n_q, n_d, cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              xfer;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HDR_LO;
            lo_q    <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= BASE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end
    // Outputs decode registered state only, so reset drops mem_wr asynchronously.
    assign in_ready  = state_q inside {HDR_LO, HDR_HI, B0, B1, B2};
    assign mem_wr    = state_q == WR;
    assign core_hold = state_q != DONE;
    assign done      = state_q == DONE;
    assign err       = state_q == ERR;
    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign xfer      = in_valid && in_ready;
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            HDR_LO: if (xfer) begin
                lo_d    = in_data;
                state_d = HDR_HI;
            end
            HDR_HI: if (xfer) begin
                n_d     = {in_data[4:0], lo_q};
                state_d = |in_data[7:5] ? ERR : ({in_data[4:0], lo_q} == 13'd0 ? DONE : B0);
            end
            B0: if (xfer) begin
                b0_d    = in_data;
                state_d = B1;
            end
            B1: if (xfer) begin
                b1_d    = in_data;
                state_d = B2;
            end
            B2: if (xfer) begin
                data_d  = DATA_W'({in_data, b1_q, b0_q});
                state_d = WR;
            end
            WR: begin
                cnt_d   = cnt_q + 13'd1;
                addr_d  = addr_q + ADDR_W'(1);
                state_d = (cnt_q + 13'd1 == n_q) ? DONE : B0;
            end
            DONE, ERR: if (start) begin
                cnt_d   = '0;
                addr_d  = BASE;
                state_d = HDR_LO;
            end
            default: state_d = HDR_LO;
        endcase
    end
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed checks of the boot loader; a second instance with BASE=8191
// receives the same stream to exercise address wrap.
module tb_mem_loader;
    logic        clk = 0, reset = 0, start = 0, in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, mem_wr, core_hold, done, err;
    logic [12:0] mem_addr;
    logic [17:0] mem_data;
    logic        w_in_ready, w_mem_wr, w_core_hold, w_done, w_err;
    logic [12:0] w_mem_addr;
    logic [17:0] w_mem_data;
    int          checks = 0, errors = 0, cyc = 0;
    logic [12:0] wa[$], wwa[$];
    logic [17:0] wd[$], wwd[$];
    int          wc[$];

    mem_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
        .core_hold(core_hold), .done(done), .err(err)
    );
    mem_loader #(.BASE(13'd8191)) dut_w (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(w_in_ready), .mem_addr(w_mem_addr), .mem_data(w_mem_data), .mem_wr(w_mem_wr),
        .core_hold(w_core_hold), .done(w_done), .err(w_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_wr) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            wc.push_back(cyc);
        end
        if (w_mem_wr) begin
            wwa.push_back(w_mem_addr);
            wwd.push_back(w_mem_data);
        end
    end

    task automatic clear_q;
        wa.delete(); wd.delete(); wc.delete(); wwa.delete(); wwd.delete();
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        in_valid = 1;
        in_data  = b;
        while (!in_ready && t < 16) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL send_ready: in_ready=%b required 1 (byte %h)", in_ready, b); end
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic send_basic;
        send(8'h02); send(8'h00);
        send(8'h34); send(8'h12); send(8'h03);
        send(8'hFF); send(8'hFF); send(8'hFF);
    endtask

    task automatic wait_done(output int c);
        int t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        c = cyc;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL done_timeout: done=%b required 1", done); end
    endtask

    task automatic pulse_start;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (mem_addr !== 13'd0) begin errors++; $display("FAIL reset_addr: got %0d required 0", mem_addr); end
        checks++; if (w_mem_addr !== 13'd8191) begin errors++; $display("FAIL reset_addr_base: got %0d required 8191", w_mem_addr); end
        checks++; if (mem_data !== 18'h0) begin errors++; $display("FAIL reset_data: got %h required 0", mem_data); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b required 0", mem_wr); end
        checks++; if ({core_hold, done, err} !== 3'b100) begin errors++; $display("FAIL reset_flags: hold/done/err got %b required 100", {core_hold, done, err}); end
        reset = 1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_basic;
        int b, d;
        clear_q();
        b = cyc;
        send_basic();
        wait_done(d);
        checks++; if (wa.size() != 2) begin errors++; $display("FAIL basic_count: got %0d writes required 2", wa.size()); end
        checks++; if (wa[0] !== 13'd0 || wd[0] !== 18'h31234) begin errors++; $display("FAIL basic_w0: got %h@%0d required 31234@0", wd[0], wa[0]); end
        checks++; if (wa[1] !== 13'd1 || wd[1] !== 18'h3FFFF) begin errors++; $display("FAIL basic_w1: got %h@%0d required 3ffff@1", wd[1], wa[1]); end
        checks++; if (wc[0] != b + 5 || wc[1] != b + 9) begin errors++; $display("FAIL basic_wr_timing: got +%0d,+%0d required +5,+9", wc[0] - b, wc[1] - b); end
        checks++; if (d != b + 10) begin errors++; $display("FAIL basic_done_timing: got +%0d required +10", d - b); end
        checks++; if (core_hold !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_release: hold/ready got %b%b required 00", core_hold, in_ready); end
        checks++; if (mem_data !== 18'h3FFFF) begin errors++; $display("FAIL basic_hold_data: got %h required 3ffff", mem_data); end
    endtask

    task automatic test_stall;
        logic [7:0] img [8] = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h03, 8'hFF, 8'hFF, 8'hFF};
        int gap [8] = '{3, 0, 2, 5, 1, 2, 4, 2};
        int d;
        pulse_start();
        clear_q();
        for (int i = 0; i < 8; i++) begin
            in_valid = 0;
            in_data  = 8'hA5;
            for (int g = 0; g < gap[i]; g++) begin
                @(negedge clk);
                if (i != 5) begin
                    checks++;
                    if (in_ready !== 1'b1 || mem_wr !== 1'b0 || done !== 1'b0) begin
                        errors++; $display("FAIL stall_frozen: ready/wr/done got %b%b%b required 100 (byte %0d)", in_ready, mem_wr, done, i);
                    end
                end
            end
            send(img[i]);
        end
        wait_done(d);
        checks++; if (wa.size() != 2) begin errors++; $display("FAIL stall_count: got %0d writes required 2", wa.size()); end
        checks++; if (wa[0] !== 13'd0 || wd[0] !== 18'h31234 || wa[1] !== 13'd1 || wd[1] !== 18'h3FFFF) begin
            errors++; $display("FAIL stall_writes: got %h@%0d %h@%0d required 31234@0 3ffff@1", wd[0], wa[0], wd[1], wa[1]);
        end
    endtask

    task automatic test_zero_bad;
        pulse_start();
        clear_q();
        send(8'h00); send(8'h00);
        checks++; if (done !== 1'b1 || core_hold !== 1'b0) begin errors++; $display("FAIL zero_done: done/hold got %b%b required 10", done, core_hold); end
        checks++; if (wa.size() != 0) begin errors++; $display("FAIL zero_nowrite: got %0d writes required 0", wa.size()); end
        pulse_start();
        send(8'h01); send(8'h20);
        checks++; if ({err, core_hold, in_ready, done} !== 4'b1100) begin errors++; $display("FAIL bad_hdr: err/hold/ready/done got %b required 1100", {err, core_hold, in_ready, done}); end
        in_valid = 1;
        repeat (3) @(negedge clk);
        in_valid = 0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", err); end
        pulse_start();
        checks++; if (err !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL err_restart: err/ready got %b%b required 01", err, in_ready); end
    endtask

    task automatic test_wrap;
        int d;
        clear_q();
        send(8'h02); send(8'h00);
        send(8'h01); send(8'h00); send(8'h00);
        send(8'hCD); send(8'hAB); send(8'hFE);
        wait_done(d);
        checks++; if (wwa.size() != 2) begin errors++; $display("FAIL wrap_count: got %0d writes required 2", wwa.size()); end
        checks++; if (wwa[0] !== 13'd8191 || wwd[0] !== 18'h00001) begin errors++; $display("FAIL wrap_w0: got %h@%0d required 00001@8191", wwd[0], wwa[0]); end
        checks++; if (wwa[1] !== 13'd0 || wwd[1] !== 18'h2ABCD) begin errors++; $display("FAIL wrap_w1: got %h@%0d required 2abcd@0", wwd[1], wwa[1]); end
        checks++; if (w_done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b required 1", w_done); end
    endtask

    task automatic test_reset_mid;
        int d;
        pulse_start();
        send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'h03);
        checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL mid_wr_active: got %b required 1", mem_wr); end
        #1 reset = 0;
        #1;
        checks++; if (mem_wr !== 1'b0 || mem_addr !== 13'd0) begin errors++; $display("FAIL mid_wr_drop: wr=%b addr=%0d required 0,0", mem_wr, mem_addr); end
        @(negedge clk);
        reset = 1;
        send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'h03); send(8'hFF); send(8'hFF);
        checks++; if (mem_addr !== 13'd1 || mem_data !== 18'h31234) begin errors++; $display("FAIL mid_pre: got %h@%0d required 31234@1", mem_data, mem_addr); end
        #2 reset = 0;
        #1;
        checks++; if (mem_addr !== 13'd0 || mem_data !== 18'h0 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL mid_reset_out: got %h@%0d wr=%b required 0@0 wr=0", mem_data, mem_addr, mem_wr);
        end
        checks++; if ({core_hold, done, err} !== 3'b100) begin errors++; $display("FAIL mid_reset_flags: got %b required 100", {core_hold, done, err}); end
        @(negedge clk);
        reset = 1;
        clear_q();
        send_basic();
        wait_done(d);
        checks++; if (wa.size() != 2 || wa[0] !== 13'd0 || wd[0] !== 18'h31234 || wa[1] !== 13'd1 || wd[1] !== 18'h3FFFF) begin
            errors++; $display("FAIL mid_reload: %0d writes %h@%0d %h@%0d required 31234@0 3ffff@1", wa.size(), wd[0], wa[0], wd[1], wa[1]);
        end
    endtask

    task automatic test_reload;
        int d;
        pulse_start();
        checks++; if (core_hold !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reload_start: hold/done/ready got %b%b%b required 101", core_hold, done, in_ready);
        end
        clear_q();
        send(8'h01); send(8'h00); send(8'h55);
        pulse_start();
        checks++; if (in_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reload_b1_start: ready/done/err got %b%b%b required 100", in_ready, done, err); end
        send(8'h55); send(8'h01);
        wait_done(d);
        checks++; if (wa.size() != 1 || wa[0] !== 13'd0 || wd[0] !== 18'h15555) begin
            errors++; $display("FAIL reload_write: %0d writes %h@%0d required 1 write 15555@0", wa.size(), wd[0], wa[0]);
        end
        repeat (3) @(negedge clk);
        checks++; if (mem_data !== 18'h15555 || done !== 1'b1) begin errors++; $display("FAIL reload_hold: data=%h done=%b required 15555,1", mem_data, done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_bad();
        test_wrap();
        test_reset_mid();
        test_reload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
